// File: rtl/bullet_pool.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_pool
//  Description : Fixed pool of N_BULLETS player bullets. Spawns into the
//                lowest idle slot on shoot (rate-limited by a tick-based
//                cooldown), moves flying bullets up one row per tick,
//                retires them on hit or after leaving row 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module bullet_pool #(
    parameter int N_BULLETS      = 4,
    parameter int X_W            = 5,
    parameter int Y_W            = 4,
    parameter int SPAWN_Y        = 12,
    parameter int PARK_Y         = 15,
    parameter int TICK_CYCLES    = 90000,
    parameter int COOLDOWN_TICKS = 2
) (
    input  logic                       clk_36MHz,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       shoot,
    input  logic [X_W-1:0]             ship_x,
    input  logic [N_BULLETS-1:0]       hit,
    output logic [N_BULLETS-1:0]       flying,
    output logic [N_BULLETS*X_W-1:0]   bullet_x,
    output logic [N_BULLETS*Y_W-1:0]   bullet_y,
    output logic                       fired,
    output logic                       full
);

    localparam int c_TICK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int c_CD_W   = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [c_CD_W-1:0]   c_CD_LOAD   = c_CD_W'(COOLDOWN_TICKS);
    localparam logic [c_CD_W-1:0]   c_CD_ONE    = c_CD_W'(1);
    localparam logic [Y_W-1:0]      c_SPAWN_Y   = Y_W'(SPAWN_Y);
    localparam logic [Y_W-1:0]      c_PARK_Y    = Y_W'(PARK_Y);
    localparam logic [Y_W-1:0]      c_Y_ONE     = Y_W'(1);

    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_CD_W-1:0]    r_cooldown;
    logic                 r_fired;
    logic                 w_tick;
    logic                 w_spawn;
    logic                 w_found;
    logic [N_BULLETS-1:0] w_spawn_sel;
    logic [N_BULLETS-1:0] w_flying;

    // Movement tick: one cycle out of every TICK_CYCLES enabled cycles
    assign w_tick = enable && (r_tick_cnt == c_TICK_LAST);

    // Free-running tick phase counter, frozen while disabled
    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (enable) begin
            if (r_tick_cnt == c_TICK_LAST) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
            end
        end
    end

    // Pick the lowest slot idle at the start of the cycle; a slot retiring
    // this cycle still reads as flying, so it cannot be reused until next cycle
    always_comb begin
        w_spawn_sel = '0;
        w_found     = 1'b0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (!w_flying[i] && !w_found) begin
                w_spawn_sel[i] = 1'b1;
                w_found        = 1'b1;
            end
        end
        w_spawn = enable && shoot && (r_cooldown == '0) && w_found;
    end

    // Cooldown: reload on spawn (wins over a coincident tick), count down on ticks
    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            r_cooldown <= '0;
        end else if (w_spawn) begin
            r_cooldown <= c_CD_LOAD;
        end else if (w_tick && (r_cooldown != '0)) begin
            r_cooldown <= r_cooldown - c_CD_ONE;
        end
    end

    // Fired pulse is the registered spawn strobe
    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            r_fired <= 1'b0;
        end else begin
            r_fired <= w_spawn;
        end
    end

    generate
        for (genvar gi = 0; gi < N_BULLETS; gi++) begin : g_slot
            logic           r_fly;
            logic [X_W-1:0] r_x;
            logic [Y_W-1:0] r_y;

            // Slot state: hit retires first, then spawn, then tick movement
            always_ff @(posedge clk_36MHz) begin
                if (reset) begin
                    r_fly <= 1'b0;
                    r_x   <= '0;
                    r_y   <= c_PARK_Y;
                end else if (r_fly && hit[gi]) begin
                    r_fly <= 1'b0;
                    r_x   <= '0;
                    r_y   <= c_PARK_Y;
                end else if (w_spawn && w_spawn_sel[gi]) begin
                    r_fly <= 1'b1;
                    r_x   <= ship_x;
                    r_y   <= c_SPAWN_Y;
                end else if (w_tick && r_fly) begin
                    if (r_y == '0) begin
                        r_fly <= 1'b0;
                        r_x   <= '0;
                        r_y   <= c_PARK_Y;
                    end else begin
                        r_y   <= r_y - c_Y_ONE;
                    end
                end
            end

            assign w_flying[gi]                = r_fly;
            assign bullet_x[gi*X_W +: X_W]     = r_x;
            assign bullet_y[gi*Y_W +: Y_W]     = r_y;
        end
    endgenerate

    assign flying = w_flying;
    assign fired  = r_fired;
    assign full   = &w_flying;

endmodule
`default_nettype wire

// File: doc/bullet_pool.md
BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N_BULLETS, 4, number of independent bullet slots (1..8)
- X_W, 5, column coordinate width
- Y_W, 4, row coordinate width
- SPAWN_Y, 12, row loaded into a slot on spawn
- PARK_Y, 15, row value of an idle slot
- TICK_CYCLES, 90000, clock cycles per movement tick (>=2)
- COOLDOWN_TICKS, 2, ticks after a spawn before the next spawn is allowed (0 = no cooldown)
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_36MHz, in, 1, sole clock
- reset, in, 1, synchronous, active-high reset
- enable, in, 1, 1 = run; 0 = freeze tick counter, movement and spawning
- shoot, in, 1, level request to fire
- ship_x, in, X_W, column of ship, captured on spawn
- hit, in, N_BULLETS, per-slot collision, retires that slot
- flying, out, N_BULLETS, per-slot active flag
- bullet_x, out, N_BULLETS*X_W, packed columns, slot i at [i*X_W +: X_W]
- bullet_y, out, N_BULLETS*Y_W, packed rows, slot i at [i*Y_W +: Y_W]
- fired, out, 1, one-cycle pulse on the cycle a spawn is registered
- full, out, 1, all slots flying

Function
REQ-003 Internal tick counter SHALL count 0..TICK_CYCLES-1 while enable=1, wrap to 0, and assert internal tick for exactly the cycle it equals TICK_CYCLES-1; it SHALL hold when enable=0.
REQ-004 Spawn condition SHALL be: enable=1, shoot=1, cooldown=0, and at least one slot with flying=0 at the start of the cycle.
REQ-005 On spawn the lowest-index idle slot SHALL register flying=1, x=ship_x, y=SPAWN_Y, and fired SHALL be 1 on the following cycle only.
REQ-006 Only one slot SHALL spawn per cycle; a held shoot SHALL spawn again only once cooldown has returned to 0.
REQ-007 On spawn cooldown SHALL load COOLDOWN_TICKS; while nonzero it SHALL decrement by 1 on each tick; a spawn and a tick in the same cycle SHALL load, not decrement.
REQ-008 A flying slot with hit[i]=1 SHALL retire next cycle (flying=0, x=0, y=PARK_Y) regardless of enable or tick.
REQ-009 On tick, a flying slot with hit[i]=0 and y>0 SHALL decrement y by 1; with y=0 it SHALL retire (row 0 is displayed for one full tick period).
REQ-010 hit SHALL take priority over tick movement for the same slot in the same cycle.
REQ-011 A slot retiring in cycle n SHALL NOT be eligible for spawn in cycle n; it becomes eligible in cycle n+1.
REQ-012 A slot spawning in a tick cycle SHALL NOT move in that cycle.
REQ-013 hit[i] on an idle slot SHALL be ignored.
REQ-014 Idle slots SHALL hold x=0, y=PARK_Y; x of a flying slot SHALL never change.
REQ-015 full SHALL be combinational AND of flying; y arithmetic SHALL never wrap below 0.
REQ-016 With enable=0 all slot positions, cooldown and tick counter SHALL hold; only hit retirement is active.

Reset
REQ-017 With reset=1 at a clock edge, all slots SHALL become flying=0, x=0, y=PARK_Y; fired=0; cooldown=0; tick counter=0, overriding all other inputs including mid-flight bullets.
REQ-018 The first spawn SHALL be possible on the first edge after reset deasserts.

Verification (TICK_CYCLES=4, COOLDOWN_TICKS=2, N_BULLETS=4)
REQ-019 Single shot: shoot 1 cycle, ship_x=7 -> slot0 flying, x=7, y=12; fired 1 cycle; y reaches 0 after 12 ticks, retires on 13th tick (y=15, x=0).
REQ-020 Held shoot: shoot constant, ship_x=3 -> spawns into slots 0,1,2,3 spaced by 2 ticks each; full=1 after 4th; no further fired while full.
REQ-021 Hit vs tick: hit[1]=1 in the tick cycle with slot1 at y=5 -> slot1 retires (y=15), not y=4; other slots move normally.
REQ-022 Retire/spawn race: all full, hit[0] and shoot same cycle, cooldown 0 -> no spawn that cycle; slot0 spawns next cycle.
REQ-023 Freeze: enable=0 for 20 cycles mid-flight -> all y, cooldown, tick phase unchanged; shoot ignored; hit still retires.
REQ-024 Reset mid-flight: reset=1 with 3 slots flying and cooldown=2 -> all outputs at reset values next cycle; shoot right after reset spawns into slot0.
